// File: rtl/bsg_sort_pkg.sv
// Shared types and sizing helpers for the iterative odd-even transposition sorter.
package bsg_sort_pkg;

   typedef enum logic [1:0] {
      e_idle,
      e_sort,
      e_done
   } sort_state_e;

   localparam int MaxEls = 64;

   // A full sort never exceeds the inversion bound els*(els-1)/2; keep at least one bit.
   function automatic int swap_width(input int els);
      int w;
      w = $clog2(els * (els - 1) / 2 + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/bsg_sort_cas_lane.sv
// One compare-and-swap lane: orders a pair for the requested direction and flags a swap.
module bsg_sort_cas_lane #(
   parameter int width_p  = 8,
   parameter int signed_p = 0
) (
   input  logic [width_p-1:0] a_i,
   input  logic [width_p-1:0] b_i,
   input  logic               descending_i,
   output logic [width_p-1:0] lo_o,
   output logic [width_p-1:0] hi_o,
   output logic               swapped_o
);

   logic aGtB;
   logic aLtB;

   if (signed_p != 0) begin : g_signed
      assign aGtB = $signed(a_i) > $signed(b_i);
      assign aLtB = $signed(a_i) < $signed(b_i);
   end else begin : g_unsigned
      assign aGtB = a_i > b_i;
      assign aLtB = a_i < b_i;
   end

   // Strict compares keep equal elements in place, which makes the sort stable.
   assign swapped_o = descending_i ? aLtB : aGtB;
   assign lo_o      = swapped_o ? b_i : a_i;
   assign hi_o      = swapped_o ? a_i : b_i;

endmodule

// File: rtl/bsg_sort_iterative.sv
// Iterative odd-even transposition sorter: one phase of parallel compare-and-swap per cycle,
// with early exit after two consecutive swap-free phases.
module bsg_sort_iterative
   import bsg_sort_pkg::*;
#(
   parameter int width_p  = 8,
   parameter int els_p    = 4,
   parameter int signed_p = 0
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic                              v_i,
   output logic                              ready_o,
   input  logic                              descending_i,
   input  logic [width_p*els_p-1:0]          data_i,
   output logic                              v_o,
   input  logic                              yumi_i,
   output logic [width_p*els_p-1:0]          data_o,
   output logic [swap_width(els_p)-1:0]      swaps_o,
   output logic [$clog2(els_p+1)-1:0]        phases_o
);

   localparam int SwapW    = swap_width(els_p);
   localparam int PhaseW   = $clog2(els_p + 1);
   localparam int NumLanes = (els_p / 2 > 0) ? els_p / 2 : 1;

   sort_state_e          state_q;
   logic [width_p-1:0]   el_q [els_p];
   logic [width_p-1:0]   el_d [els_p];
   logic [SwapW-1:0]     swaps_q;
   logic [PhaseW-1:0]    phases_q;
   logic                 desc_q;
   logic                 prevZero_q;

   logic                 oddPhase;
   logic [width_p-1:0]   laneA  [NumLanes];
   logic [width_p-1:0]   laneB  [NumLanes];
   logic [width_p-1:0]   laneLo [NumLanes];
   logic [width_p-1:0]   laneHi [NumLanes];
   logic [NumLanes-1:0]  laneSwap;
   logic [NumLanes-1:0]  laneValid;
   logic [SwapW-1:0]     phaseSwaps;
   logic                 phaseZero;
   logic                 lastPhase;

   assign oddPhase = phases_q[0];

   // Lane k serves pair (2k,2k+1) on even phases and (2k+1,2k+2) on odd phases.
   for (genvar k = 0; k < NumLanes; k++) begin : g_lane
      localparam int EA = (2*k < els_p) ? 2*k : 0;
      localparam int EB = (2*k + 1 < els_p) ? 2*k + 1 : EA;
      localparam int OA = (2*k + 1 < els_p) ? 2*k + 1 : EA;
      localparam int OB = (2*k + 2 < els_p) ? 2*k + 2 : OA;
      localparam bit EValid = (2*k + 1 < els_p);
      localparam bit OValid = (2*k + 2 < els_p);

      assign laneA[k]     = oddPhase ? el_q[OA] : el_q[EA];
      assign laneB[k]     = oddPhase ? el_q[OB] : el_q[EB];
      assign laneValid[k] = oddPhase ? OValid : EValid;

      bsg_sort_cas_lane #(
         .width_p (width_p),
         .signed_p(signed_p)
      ) u_lane (
         .a_i         (laneA[k]),
         .b_i         (laneB[k]),
         .descending_i(desc_q),
         .lo_o        (laneLo[k]),
         .hi_o        (laneHi[k]),
         .swapped_o   (laneSwap[k])
      );
   end

   for (genvar i = 0; i < els_p; i++) begin : g_el
      localparam bit EvenLo = (i % 2 == 0) && (i + 1 < els_p);
      localparam bit EvenHi = (i % 2 == 1);
      localparam bit OddLo  = (i % 2 == 1) && (i + 1 < els_p);
      localparam bit OddHi  = (i % 2 == 0) && (i >= 2);

      logic [width_p-1:0] evenV;
      logic [width_p-1:0] oddV;

      if (EvenLo) begin : g_elo
         assign evenV = laneLo[i/2];
      end else if (EvenHi) begin : g_ehi
         assign evenV = laneHi[i/2];
      end else begin : g_ehold
         assign evenV = el_q[i];
      end

      if (OddLo) begin : g_olo
         assign oddV = laneLo[i/2];
      end else if (OddHi) begin : g_ohi
         assign oddV = laneHi[i/2 - 1];
      end else begin : g_ohold
         assign oddV = el_q[i];
      end

      assign el_d[i] = oddPhase ? oddV : evenV;
      assign data_o[i*width_p +: width_p] = el_q[i];
   end

   always_comb begin
      phaseSwaps = '0;
      for (int k = 0; k < NumLanes; k++) begin
         phaseSwaps = phaseSwaps + SwapW'(laneSwap[k] & laneValid[k]);
      end
   end

   assign phaseZero = (phaseSwaps == '0);
   assign lastPhase = (phases_q == PhaseW'(els_p - 1));

   // Controller and datapath registers; prevZero_q clears on accept so the first phase
   // can never trigger the early exit on its own.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= e_idle;
         swaps_q    <= '0;
         phases_q   <= '0;
         desc_q     <= 1'b0;
         prevZero_q <= 1'b0;
         for (int i = 0; i < els_p; i++) el_q[i] <= '0;
      end else begin
         case (state_q)
            e_idle: begin
               if (v_i) begin
                  for (int i = 0; i < els_p; i++) el_q[i] <= data_i[i*width_p +: width_p];
                  desc_q     <= descending_i;
                  swaps_q    <= '0;
                  phases_q   <= '0;
                  prevZero_q <= 1'b0;
                  state_q    <= (els_p == 1) ? e_done : e_sort;
               end
            end
            e_sort: begin
               for (int i = 0; i < els_p; i++) el_q[i] <= el_d[i];
               swaps_q    <= swaps_q + phaseSwaps;
               phases_q   <= phases_q + PhaseW'(1);
               prevZero_q <= phaseZero;
               if (lastPhase || (phaseZero && prevZero_q)) state_q <= e_done;
            end
            e_done: begin
               if (yumi_i) state_q <= e_idle;
            end
            default: state_q <= e_idle;
         endcase
      end
   end

   assign ready_o  = reset_n_i && (state_q == e_idle);
   assign v_o      = (state_q == e_done);
   assign swaps_o  = swaps_q;
   assign phases_o = phases_q;

   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_sort_iterative.sv
// Table-driven, scoreboarded bench for bsg_sort_iterative (4 x 8-bit, unsigned and signed).
module tb_bsg_sort_iterative;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int DW = W * N;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          v_i, yumi, desc;
   logic [DW-1:0] data_i;
   logic          ready, v_o;
   logic [DW-1:0] data_o;
   logic [2:0]    swaps, phases;

   logic          vS, yumiS;
   logic          readyS, vOS;
   logic [DW-1:0] dataOS;
   logic [2:0]    swapsS, phasesS;

   int nChecks = 0;
   int nFails  = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic          desc;
      logic [DW-1:0] expData;
      int            expSwaps;
      int            expPhases;
      int            expLat;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   bsg_sort_iterative #(.width_p(W), .els_p(N), .signed_p(0)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_o(ready),
      .descending_i(desc), .data_i(data_i), .v_o(v_o), .yumi_i(yumi),
      .data_o(data_o), .swaps_o(swaps), .phases_o(phases)
   );

   bsg_sort_iterative #(.width_p(W), .els_p(N), .signed_p(1)) dutS (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(vS), .ready_o(readyS),
      .descending_i(desc), .data_i(data_i), .v_o(vOS), .yumi_i(yumiS),
      .data_o(dataOS), .swaps_o(swapsS), .phases_o(phasesS)
   );

   function automatic logic [DW-1:0] pack(input logic [7:0] e0, e1, e2, e3);
      return {e3, e2, e1, e0};
   endfunction

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Independent reference: insertion sort plus inversion count (= adjacent swaps needed).
   function automatic vec_t makeRandom(input logic [DW-1:0] d, input logic dsc);
      vec_t v;
      logic [7:0] e [N];
      logic [7:0] t;
      int inv = 0;
      for (int i = 0; i < N; i++) e[i] = d[i*W +: W];
      for (int i = 0; i < N; i++)
         for (int j = i + 1; j < N; j++)
            if (dsc ? (e[i] < e[j]) : (e[i] > e[j])) inv++;
      for (int i = 1; i < N; i++)
         for (int j = i; j > 0; j--)
            if (dsc ? (e[j-1] < e[j]) : (e[j-1] > e[j])) begin
               t = e[j]; e[j] = e[j-1]; e[j-1] = t;
            end
      v.data = d; v.desc = dsc;
      v.expData = pack(e[0], e[1], e[2], e[3]);
      v.expSwaps = inv; v.expPhases = -1; v.expLat = -1;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      int cnt = 0;
      @(negedge clk);
      while (!ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      checkVal("readyBeforeLoad", ready, 1);
      data_i = v.data;
      desc   = v.desc;
      v_i    = 1'b1;
      sb.push_back(v);
      @(negedge clk);
      v_i = 1'b0;
   endtask

   task automatic checkOutput();
      vec_t exp;
      int lat = 1;
      while (!v_o && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkVal("vOutTimeout", v_o, 1);
      checkVal("scoreboardNotEmpty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
         exp = sb.pop_front();
         checkVal("dataOut", data_o, exp.expData);
         checkVal("swapsOut", swaps, exp.expSwaps);
         if (exp.expPhases >= 0) checkVal("phasesOut", phases, exp.expPhases);
         if (exp.expLat >= 0) checkVal("latency", lat, exp.expLat);
         checkVal("readyInDone", ready, 0);
      end
   endtask

   task automatic releaseOutput();
      yumi = 1'b1;
      v_i  = 1'b0;
      @(negedge clk);
      yumi = 1'b0;
      checkVal("readyAfterYumi", ready, 1);
      checkVal("vAfterYumi", v_o, 0);
   endtask

   initial begin
      vec_t v;
      logic [DW-1:0] held;
      int cnt;

      reset_n = 1'b0; v_i = 1'b0; yumi = 1'b0; desc = 1'b0; data_i = '0;
      vS = 1'b0; yumiS = 1'b0;

      tbl.push_back('{pack(3,1,4,2), 1'b0, pack(1,2,3,4), 3, 4, 5});
      tbl.push_back('{pack(4,3,2,1), 1'b0, pack(1,2,3,4), 6, 4, 5});
      tbl.push_back('{pack(3,1,4,2), 1'b1, pack(4,3,2,1), 3, 4, 5});
      tbl.push_back('{pack(1,2,3,4), 1'b0, pack(1,2,3,4), 0, 2, 3});
      tbl.push_back('{pack(8'h7F,8'h80,8'h00,8'hFF), 1'b0, pack(8'h00,8'h7F,8'h80,8'hFF), 2, 4, 5});
      for (int r = 0; r < 4; r++)
         tbl.push_back(makeRandom({$urandom_range(0,255), $urandom_range(0,255)}, 1'(r % 2)));

      repeat (3) @(negedge clk);
      #1;
      checkVal("resetReady", ready, 0);
      checkVal("resetValid", v_o, 0);
      checkVal("resetData", data_o, 0);
      checkVal("resetSwaps", swaps, 0);
      checkVal("resetPhases", phases, 0);
      reset_n = 1'b1;
      #1;
      checkVal("readyAfterReset", ready, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i]);
         checkOutput();
         releaseOutput();
      end

      // Signed compare on the second instance.
      @(negedge clk);
      data_i = pack(8'h7F, 8'h80, 8'h00, 8'hFF);
      desc = 1'b0;
      vS = 1'b1;
      @(negedge clk);
      vS = 1'b0;
      cnt = 1;
      while (!vOS && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      checkVal("signedValid", vOS, 1);
      checkVal("signedData", dataOS, pack(8'h80, 8'hFF, 8'h00, 8'h7F));
      checkVal("signedSwaps", swapsS, 4);
      checkVal("signedPhases", phasesS, 4);
      yumiS = 1'b1;
      @(negedge clk);
      yumiS = 1'b0;
      checkVal("signedReadyAfterYumi", readyS, 1);

      // Backpressure: output held, new vectors ignored while in DONE.
      applyStimulus('{pack(3,1,4,2), 1'b0, pack(1,2,3,4), 3, 4, 5});
      checkOutput();
      held = pack(1,2,3,4);
      for (int c = 0; c < 10; c++) begin
         v_i = 1'b1;
         data_i = {$urandom(), 32'h0} >> 32;
         desc = 1'(c % 2);
         @(negedge clk);
         checkVal("bpData", data_o, held);
         checkVal("bpReady", ready, 0);
         checkVal("bpValid", v_o, 1);
      end
      checkVal("bpSwaps", swaps, 3);
      releaseOutput();

      // Reset during cycle 2 of SORT discards the vector.
      @(negedge clk);
      data_i = pack(4,3,2,1);
      desc = 1'b0;
      v_i = 1'b1;
      @(negedge clk);
      v_i = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkVal("midResetValid", v_o, 0);
      checkVal("midResetReady", ready, 0);
      checkVal("midResetData", data_o, 0);
      checkVal("midResetSwaps", swaps, 0);
      checkVal("midResetPhases", phases, 0);
      @(negedge clk);
      checkVal("midResetReadyHeld", ready, 0);
      reset_n = 1'b1;
      #1;
      checkVal("readyAfterMidReset", ready, 1);
      applyStimulus('{pack(2,2,1,1), 1'b0, pack(1,1,2,2), 4, 4, 5});
      checkOutput();
      releaseOutput();

      checkVal("scoreboardDrained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: got timeout, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/bsg_sort_iterative.md
Name: bsg_sort_iterative

Overview:
- Iterative odd-even transposition sorter for a vector of els_p unsigned or signed words.
- Captures a vector via valid/ready, then sorts it in place. Each cycle runs one phase of parallel compare-and-swap lanes.
- Presents the sorted vector with swap and phase statistics on a valid/yumi output.
- Sits where a single compare-and-swap is too narrow: small priority/ordering stages, e.g. top-k selection ahead of arbiters.

Parameters:
- width_p, 8, bit width of one element.
- els_p, 4, number of elements; legal range 1..64.
- signed_p, 0, 1 = compare elements as two's-complement, 0 = unsigned.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- v_i  in  1  input vector valid.
- ready_o  out  1  block can accept a vector.
- descending_i  in  1  sort direction, sampled with v_i & ready_o; 0 = ascending.
- data_i  in  width_p*els_p  element k = data_i[k*width_p +: width_p].
- v_o  out  1  sorted vector valid.
- yumi_i  in  1  consumer takes the output; legal only while v_o = 1.
- data_o  out  width_p*els_p  sorted vector, same packing as data_i.
- swaps_o  out  $clog2(els_p*(els_p-1)/2+1) (min 1)  total swaps performed.
- phases_o  out  $clog2(els_p+1)  phases executed.

Behaviour:
- Reset (async assert, sync-deasserted externally):
  - state = IDLE; element registers, swaps_o, phases_o and the direction flag clear to 0.
  - v_o = 0.
  - ready_o = 0 while reset_n_i is low, 1 in IDLE afterwards.
- FSM IDLE -> SORT -> DONE -> IDLE. ready_o = (state == IDLE); v_o = (state == DONE).
- IDLE:
  - On v_i & ready_o: load data_i, latch descending_i, clear counters.
  - Go to SORT, or straight to DONE when els_p == 1.
- SORT, one phase per cycle; phase p uses the parity of phases count:
  - Even phase pairs: (0,1), (2,3), ...
  - Odd phase pairs: (1,2), (3,4), ...
  - Unpaired end elements hold their value.
  - Pair (j, j+1) swaps iff el[j] > el[j+1] (ascending) or el[j] < el[j+1] (descending). Compare is signed when signed_p = 1.
  - Equal elements never swap, so the sort is stable.
  - Each phase adds its swap count to swaps_o and increments phases_o.
- SORT exit, taking effect the next cycle into DONE, on either condition:
  - phases_o reaches els_p, including the current phase.
  - Two consecutive phases each produced zero swaps; the first SORT phase has no predecessor.
- Latency:
  - Accept at cycle 0, SORT occupies cycles 1..P, v_o first high at cycle P+1.
  - P <= els_p; P = 2 for an already-sorted input with els_p >= 2.
- DONE:
  - data_o, swaps_o and phases_o are held stable until yumi_i.
  - On yumi_i, go to IDLE; ready_o rises the next cycle. There is no accept in the same cycle as yumi_i.
- v_i is ignored outside IDLE; data_i and descending_i are don't-care then.
- yumi_i without v_o is illegal; an assertion flags it.
- Reset mid-SORT or mid-DONE aborts immediately; partial data is discarded and all outputs take reset values.
- Counters cannot overflow: swaps <= els_p*(els_p-1)/2, the inversion bound.

Decomposition:
- Package bsg_sort_pkg:
  - state enum {e_idle, e_sort, e_done}.
  - Function for the swap-count width.
  - Localparam for the maximum els_p.
- Sub-module bsg_sort_cas_lane: parametrised width_p/signed_p.
  - Inputs: a, b, descending.
  - Outputs: lo/hi-ordered pair plus a swapped flag.
  - Top level instantiates floor(els_p/2) lanes and muxes pair indices by phase parity.
- A popcount of the lane swapped flags feeds swaps_o.

Test Plan:
- els_p=4, width_p=8, ascending, data {3,1,4,2} (el0 first) -> data_o {1,2,3,4}, swaps_o=3, phases_o=4, v_o at cycle 5.
- Reverse input {4,3,2,1}, ascending -> {1,2,3,4}, swaps_o=6, phases_o=4; descending on {3,1,4,2} -> {4,3,2,1}.
- Already sorted {1,2,3,4} -> early exit: phases_o=2, swaps_o=0, v_o at cycle 3.
- signed_p=1, {0x7F,0x80,0x00,0xFF} ascending -> {0x80,0xFF,0x00,0x7F}; same vector with signed_p=0 -> {0x00,0x7F,0x80,0xFF}.
- Backpressure: hold yumi_i=0 for 10 cycles in DONE with v_i=1 toggling data_i -> data_o stable, ready_o=0, no reload; yumi_i pulse -> ready_o=1 next cycle.
- Reset asserted in cycle 2 of SORT -> v_o=0, ready_o=0 during reset, registers 0; after release a new vector {2,2,1,1} sorts to {1,1,2,2}, swaps_o=4.
